// File: rtl/issue_selector.sv
// Oldest-first issue selector for a reservation station.
// Picks the oldest ready row through an age matrix, holds it in a single
// issue slot until the functional unit accepts it, and schedules the
// wakeup of its destination column through a latency delay line.
module issue_selector #(
    parameter int NUM_ROWS = 8,
    parameter int NUM_COLS = 8,
    parameter int LAT_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ROWS-1:0]           ready_vector,
    input  logic                          alloc_en,
    input  logic [$clog2(NUM_ROWS)-1:0]   alloc_row_index,
    input  logic [$clog2(NUM_COLS)-1:0]   alloc_dest_col,
    input  logic [LAT_W-1:0]              alloc_latency,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [$clog2(NUM_ROWS)-1:0]   issue_row_index,
    output logic                          free_en,
    output logic [$clog2(NUM_ROWS)-1:0]   free_row_index,
    output logic                          clear_en,
    output logic [NUM_COLS-1:0]           clear_lines
);

    localparam int RW    = $clog2(NUM_ROWS);
    localparam int CW    = $clog2(NUM_COLS);
    localparam int DEPTH = (1 << LAT_W) - 1;

    // Per-row entry state
    logic [NUM_ROWS-1:0] row_valid;
    logic [CW-1:0]       row_dest [NUM_ROWS];
    logic [LAT_W-1:0]    row_lat  [NUM_ROWS];

    // older[i][j] set means row j was allocated before row i
    logic [NUM_ROWS-1:0] older [NUM_ROWS];

    // Issue slot keeps its own copy of the payload so the row can be reused
    logic                slot_valid;
    logic [RW-1:0]       slot_row;
    logic [CW-1:0]       slot_dest;
    logic [LAT_W-1:0]    slot_lat;

    // Wakeup delay line; stage 0 is what clears this cycle
    logic [NUM_COLS-1:0] wake_q [DEPTH];
    logic [NUM_COLS-1:0] inject [DEPTH];

    logic [NUM_ROWS-1:0] slot_mask;
    logic [NUM_ROWS-1:0] cand;
    logic [RW-1:0]       sel_row;
    logic                any_cand;
    logic                load;
    logic                fire;
    logic [LAT_W-1:0]    lat_idx;
    logic [NUM_COLS-1:0] wake_bit;

    // Candidate set: ready, valid and not already sitting in the slot
    always_comb begin
        slot_mask = '0;
        if (slot_valid) begin
            slot_mask[slot_row] = 1'b1;
        end
        cand = ready_vector & row_valid & ~slot_mask;
    end

    // Oldest candidate is the one with no older candidate
    always_comb begin
        sel_row = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (cand[i] && ((older[i] & cand) == '0)) begin
                sel_row = RW'(i);
            end
        end
    end

    assign any_cand        = |cand;
    assign load            = any_cand && !rst && (!slot_valid || issue_ready);
    assign issue_valid     = slot_valid && !rst;
    assign issue_row_index = slot_row;
    assign fire            = issue_valid && issue_ready;
    assign free_en         = load;
    assign free_row_index  = sel_row;

    // Latency 0 behaves as 1, so both land in stage 0
    assign lat_idx  = (slot_lat == '0) ? '0 : slot_lat - LAT_W'(1);
    assign wake_bit = NUM_COLS'(1) << slot_dest;

    // Wakeup injected into the stage matching the firing entry's latency
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            inject[k] = (fire && (lat_idx == LAT_W'(k))) ? wake_bit : '0;
        end
    end

    // Valid bits: a slot load clears after an alloc sets, so load wins
    always_ff @(posedge clk) begin
        if (rst) begin
            row_valid <= '0;
        end else begin
            if (alloc_en) begin
                row_valid[alloc_row_index] <= 1'b1;
            end
            if (load) begin
                row_valid[sel_row] <= 1'b0;
            end
        end
    end

    // Entry payload captured on alloc
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            row_dest[alloc_row_index] <= alloc_dest_col;
            row_lat[alloc_row_index]  <= alloc_latency;
        end
    end

    // Age matrix: a new row is younger than every currently valid row
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                older[i] <= '0;
            end
        end else if (alloc_en) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                for (int j = 0; j < NUM_ROWS; j++) begin
                    if (RW'(i) == alloc_row_index) begin
                        older[i][j] <= row_valid[j] && (RW'(j) != alloc_row_index);
                    end else if (RW'(j) == alloc_row_index) begin
                        older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Issue slot: load on empty or handshake, otherwise empty after a fire
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_row   <= '0;
            slot_dest  <= '0;
            slot_lat   <= '0;
        end else if (load) begin
            slot_valid <= 1'b1;
            slot_row   <= sel_row;
            slot_dest  <= row_dest[sel_row];
            slot_lat   <= row_lat[sel_row];
        end else if (fire) begin
            slot_valid <= 1'b0;
        end
    end

    // Delay line shifts toward stage 0 every cycle, merging new wakeups
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                wake_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                wake_q[k] <= wake_q[k+1] | inject[k];
            end
            wake_q[DEPTH-1] <= inject[DEPTH-1];
        end
    end

    assign clear_lines = rst ? '0 : wake_q[0];
    assign clear_en    = |clear_lines;

`ifndef SYNTHESIS
    // Allocation must never land on a live row or the row leaving this cycle
    alloc_target_free: assert property (@(posedge clk) disable iff (rst)
        alloc_en |-> (!row_valid[alloc_row_index] &&
                      !(load && (sel_row == alloc_row_index))));
`endif

endmodule
